// File: rtl/spectrum_mag_unit.sv
// rtl/spectrum_mag_unit.sv - power spectrum of the lower FFT half with scaling, saturation and peak tracking
module spectrum_mag_unit #(
    parameter int N_POINTS    = 1024,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT       = 32,
    parameter int RAM_LATENCY = 1,
    parameter int EXCLUDE_DC  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [ADDR_WIDTH-1:0]        fft_addr_o,
    input  logic signed [DATA_WIDTH-1:0] fft_real_i,
    input  logic signed [DATA_WIDTH-1:0] fft_img_i,
    output logic                         mag_we_o,
    output logic [ADDR_WIDTH-2:0]        mag_addr_o,
    output logic [OUT_WIDTH-1:0]         mag_data_o,
    output logic [ADDR_WIDTH-2:0]        peak_bin_o,
    output logic [OUT_WIDTH-1:0]         peak_val_o
);
    localparam int HALF = N_POINTS / 2;
    localparam int L    = RAM_LATENCY + 3;
    localparam int BW   = ADDR_WIDTH - 1;
    localparam int PW   = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(HALF - 1);
    localparam logic [BW-1:0]         LAST_BIN  = BW'(HALF - 1);
    localparam logic [OUT_WIDTH-1:0]  SAT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state;

    logic signed [DATA_WIDTH-1:0] s1_re, s1_im;
    logic [PW-1:0]                s2_re_sq, s2_im_sq;
    // Bin-valid and bin-index travel alongside the data so the write lands L cycles after the read.
    logic [L-2:0]                 v_pipe;
    logic [BW-1:0]                a_pipe [L-1];
    logic [OUT_WIDTH-1:0]         run_val;
    logic [BW-1:0]                run_bin;

    logic signed [PW-1:0]   re_ext, im_ext;
    logic [PW:0]            pw_sum, pw_shift;
    logic [OUT_WIDTH-1:0]   pw_sat;
    logic                   s3_valid;
    logic [BW-1:0]          s3_bin;
    logic                   peak_hit;

    // Squaring at full 2*DATA_WIDTH width keeps (-2^(DATA_WIDTH-1))^2 exact.
    always_comb begin
        re_ext   = PW'(s1_re);
        im_ext   = PW'(s1_im);
        pw_sum   = {1'b0, s2_re_sq} + {1'b0, s2_im_sq};
        pw_shift = pw_sum >> SHIFT;
        pw_sat   = (|pw_shift[PW:OUT_WIDTH]) ? SAT_MAX : pw_shift[OUT_WIDTH-1:0];
        s3_valid = v_pipe[L-2];
        s3_bin   = a_pipe[L-2];
        peak_hit = s3_valid && !((EXCLUDE_DC != 0) && (s3_bin == '0)) && (pw_sat > run_val);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            fft_addr_o <= '0;
            mag_we_o   <= 1'b0;
            mag_addr_o <= '0;
            mag_data_o <= '0;
            peak_bin_o <= '0;
            peak_val_o <= '0;
            s1_re      <= '0;
            s1_im      <= '0;
            s2_re_sq   <= '0;
            s2_im_sq   <= '0;
            v_pipe     <= '0;
            run_val    <= '0;
            run_bin    <= '0;
            for (int i = 0; i < L - 1; i++) a_pipe[i] <= '0;
        end else begin
            s1_re    <= fft_real_i;
            s1_im    <= fft_img_i;
            s2_re_sq <= $unsigned(re_ext * re_ext);
            s2_im_sq <= $unsigned(im_ext * im_ext);
            v_pipe   <= {v_pipe[L-3:0], state == READ};
            a_pipe[0] <= fft_addr_o[BW-1:0];
            for (int i = 1; i < L - 1; i++) a_pipe[i] <= a_pipe[i-1];

            mag_we_o <= s3_valid;
            if (s3_valid) begin
                mag_addr_o <= s3_bin;
                mag_data_o <= pw_sat;
            end
            if (peak_hit) begin
                run_val <= pw_sat;
                run_bin <= s3_bin;
            end

            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= READ;
                        busy_o     <= 1'b1;
                        fft_addr_o <= '0;
                        run_val    <= '0;
                        run_bin    <= '0;
                    end
                end
                READ: begin
                    if (fft_addr_o == LAST_ADDR) state <= DRAIN;
                    else fft_addr_o <= fft_addr_o + 1'b1;
                end
                DRAIN: begin
                    // The last bin's write is on the bus now, and the running max already includes it.
                    if (mag_we_o && (mag_addr_o == LAST_BIN)) begin
                        state      <= DONE;
                        done_o     <= 1'b1;
                        busy_o     <= 1'b0;
                        peak_bin_o <= run_bin;
                        peak_val_o <= run_val;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spectrum_mag_unit.sv
// tb/tb_spectrum_mag_unit.sv - bench for spectrum_mag_unit: default instance plus a RAM_LATENCY=3, EXCLUDE_DC=0 instance
module tb_spectrum_mag_unit;
    localparam int HALF = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic start_i = 1'b0;
    int   cyc = 0;
    logic st_q, rs_q;
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        st_q <= start_i;
        rs_q <= rst_n;
    end

    logic signed [31:0] mem_re [HALF];
    logic signed [31:0] mem_im [HALF];

    logic        busy [2];
    logic        done [2];
    logic [9:0]  faddr [2];
    logic        we [2];
    logic [8:0]  maddr [2];
    logic [15:0] mdata [2];
    logic [8:0]  pbin [2];
    logic [15:0] pval [2];
    logic signed [31:0] rd_re [2][3];
    logic signed [31:0] rd_im [2][3];

    always @(posedge clk) begin
        rd_re[0][0] <= mem_re[faddr[0][8:0]];
        rd_im[0][0] <= mem_im[faddr[0][8:0]];
        rd_re[1][0] <= mem_re[faddr[1][8:0]];
        rd_im[1][0] <= mem_im[faddr[1][8:0]];
        rd_re[1][1] <= rd_re[1][0];
        rd_im[1][1] <= rd_im[1][0];
        rd_re[1][2] <= rd_re[1][1];
        rd_im[1][2] <= rd_im[1][1];
    end

    spectrum_mag_unit u0 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy[0]), .done_o(done[0]),
        .fft_addr_o(faddr[0]), .fft_real_i(rd_re[0][0]), .fft_img_i(rd_im[0][0]),
        .mag_we_o(we[0]), .mag_addr_o(maddr[0]), .mag_data_o(mdata[0]),
        .peak_bin_o(pbin[0]), .peak_val_o(pval[0])
    );

    spectrum_mag_unit #(.RAM_LATENCY(3), .EXCLUDE_DC(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy[1]), .done_o(done[1]),
        .fft_addr_o(faddr[1]), .fft_real_i(rd_re[1][2]), .fft_img_i(rd_im[1][2]),
        .mag_we_o(we[1]), .mag_addr_o(maddr[1]), .mag_data_o(mdata[1]),
        .peak_bin_o(pbin[1]), .peak_val_o(pval[1])
    );

    int total = 0;
    int bad = 0;

    task automatic check(input int inst, input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL u%0d %s cyc=%0d got=%0d want=%0d", inst, nm, cyc, act, exp);
        end
    endtask

    // Power of one bin straight from the arithmetic definition.
    function automatic int power(input logic signed [31:0] re, input logic signed [31:0] im);
        longint r, m;
        logic [64:0] t;
        r = re;
        m = im;
        t = 65'(r * r) + 65'(m * m);
        t = t >> 32;
        if (t > 65'd65535) return 65535;
        return int'(t);
    endfunction

    // Frame-level model: which cycles carry which outputs, derived from the start cycle.
    bit act [2];
    int s_fr [2], h_fa [2], h_ma [2], h_md [2], pk_b [2], pk_v [2], f_b [2], f_v [2];
    int fpw [2][HALF];
    int cap [2][HALF];
    int wr_cnt [2], done_cnt [2], w0_cyc [2];
    int lat, dc;
    bit e_busy, e_done, e_we;

    initial begin
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; s_fr[i] = 0; h_fa[i] = 0; h_ma[i] = 0; h_md[i] = 0;
            pk_b[i] = 0; pk_v[i] = 0; wr_cnt[i] = 0; done_cnt[i] = 0; w0_cyc[i] = -1;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 2) begin
            for (int i = 0; i < 2; i++) begin
                lat = (i == 0) ? 4 : 6;
                dc  = s_fr[i] + HALF + lat + 1;
                if (!rs_q) begin
                    act[i] = 0; h_fa[i] = 0; h_ma[i] = 0; h_md[i] = 0; pk_b[i] = 0; pk_v[i] = 0;
                end else if (st_q && (!act[i] || (cyc - 1 > dc))) begin
                    act[i] = 1;
                    s_fr[i] = cyc - 1;
                    f_b[i] = 0;
                    f_v[i] = 0;
                    for (int k = 0; k < HALF; k++) begin
                        fpw[i][k] = power(mem_re[k], mem_im[k]);
                        if (!(i == 0 && k == 0) && fpw[i][k] > f_v[i]) begin
                            f_v[i] = fpw[i][k];
                            f_b[i] = k;
                        end
                    end
                end
                dc     = s_fr[i] + HALF + lat + 1;
                e_busy = act[i] && cyc >= s_fr[i] + 1 && cyc <= s_fr[i] + HALF + lat;
                e_done = act[i] && cyc == dc;
                e_we   = act[i] && cyc >= s_fr[i] + 1 + lat && cyc <= s_fr[i] + lat + HALF;
                if (act[i] && cyc >= s_fr[i] + 1 && cyc <= s_fr[i] + HALF) h_fa[i] = cyc - s_fr[i] - 1;
                if (e_we) begin
                    h_ma[i] = cyc - s_fr[i] - 1 - lat;
                    h_md[i] = fpw[i][h_ma[i]];
                end
                if (e_done) begin
                    pk_b[i] = f_b[i];
                    pk_v[i] = f_v[i];
                end
                check(i, "busy", 64'(busy[i]), 64'(e_busy));
                check(i, "done", 64'(done[i]), 64'(e_done));
                check(i, "fft_addr", 64'(faddr[i]), 64'(h_fa[i]));
                check(i, "mag_we", 64'(we[i]), 64'(e_we));
                check(i, "mag_addr", 64'(maddr[i]), 64'(h_ma[i]));
                check(i, "mag_data", 64'(mdata[i]), 64'(h_md[i]));
                check(i, "peak_bin", 64'(pbin[i]), 64'(pk_b[i]));
                check(i, "peak_val", 64'(pval[i]), 64'(pk_v[i]));
                if (we[i] === 1'b1) begin
                    wr_cnt[i]++;
                    cap[i][maddr[i]] = int'(mdata[i]);
                    if (maddr[i] == 9'd0) w0_cyc[i] = cyc;
                end
                if (done[i] === 1'b1) done_cnt[i]++;
            end
        end
    end

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mem();
        for (int k = 0; k < HALF; k++) begin
            mem_re[k] = '0;
            mem_im[k] = '0;
        end
    endtask

    task automatic run_frame(output int s);
        go_to(cyc + 2);
        s = cyc;
        start_i = 1'b1;
        go_to(s + 1);
        start_i = 1'b0;
        go_to(s + 540);
    endtask

    int fs, wc0, wc1, dn0, dn1;

    initial begin
        clear_mem();
        go_to(3);
        rst_n = 1'b1;
        go_to(10);
        check(0, "rst_peak_val", 64'(pval[0]), 64'd0);
        check(0, "rst_busy", 64'(busy[0]), 64'd0);

        // All-zero frame with stray starts mid-frame and during DONE, then a start in IDLE.
        fs = 20;
        wc0 = wr_cnt[0]; wc1 = wr_cnt[1]; dn0 = done_cnt[0]; dn1 = done_cnt[1];
        go_to(fs); start_i = 1'b1; go_to(fs + 1); start_i = 1'b0;
        go_to(fs + 50); start_i = 1'b1; go_to(fs + 51); start_i = 1'b0;
        go_to(fs + 517); start_i = 1'b1; go_to(fs + 518); start_i = 1'b0;
        go_to(fs + 520);
        check(0, "write_count", 64'(wr_cnt[0] - wc0), 64'd512);
        check(1, "write_count", 64'(wr_cnt[1] - wc1), 64'd512);
        check(0, "done_count", 64'(done_cnt[0] - dn0), 64'd1);
        check(1, "done_count", 64'(done_cnt[1] - dn1), 64'd1);
        check(0, "first_write_lat", 64'(w0_cyc[0] - fs), 64'd5);
        check(1, "first_write_lat", 64'(w0_cyc[1] - fs), 64'd7);
        start_i = 1'b1;
        go_to(fs + 521);
        start_i = 1'b0;
        check(0, "restart_addr", 64'(faddr[0]), 64'd0);
        check(0, "restart_busy", 64'(busy[0]), 64'd1);
        go_to(fs + 521 + 540);

        // Single tone in bin 5.
        clear_mem();
        mem_re[5] = 32'sd1048576;
        run_frame(fs);
        check(0, "tone_peak_bin", 64'(pbin[0]), 64'd5);
        check(0, "tone_peak_val", 64'(pval[0]), 64'd256);
        check(1, "tone_peak_bin", 64'(pbin[1]), 64'd5);
        check(0, "tone_bin5", 64'(cap[0][5]), 64'd256);
        check(0, "tone_bin4", 64'(cap[0][4]), 64'd0);

        // Most-negative input on both parts saturates.
        clear_mem();
        mem_re[7] = 32'h8000_0000;
        mem_im[7] = 32'h8000_0000;
        run_frame(fs);
        check(0, "sat_bin7", 64'(cap[0][7]), 64'd65535);
        check(1, "sat_bin7", 64'(cap[1][7]), 64'd65535);
        check(0, "sat_peak_bin", 64'(pbin[0]), 64'd7);

        // Tie between bins 3 and 9; a larger DC bin only wins when DC is a candidate.
        clear_mem();
        mem_re[3] = 32'sd655360;  mem_im[3] = 32'sd1966080;
        mem_re[9] = 32'sd1966080; mem_im[9] = 32'sd655360;
        mem_re[0] = 32'sd3276800; mem_im[0] = 32'sd3276800;
        run_frame(fs);
        check(0, "tie_peak_bin", 64'(pbin[0]), 64'd3);
        check(0, "tie_peak_val", 64'(pval[0]), 64'd1000);
        check(1, "dc_peak_bin", 64'(pbin[1]), 64'd0);
        check(1, "dc_peak_val", 64'(pval[1]), 64'd5000);

        // Reset in mid-frame aborts it; a fresh frame afterwards is normal.
        go_to(cyc + 2);
        fs = cyc;
        dn0 = done_cnt[0]; dn1 = done_cnt[1];
        start_i = 1'b1; go_to(fs + 1); start_i = 1'b0;
        go_to(fs + 200); rst_n = 1'b0; go_to(fs + 201); rst_n = 1'b1;
        check(0, "abort_peak_val", 64'(pval[0]), 64'd0);
        check(0, "abort_busy", 64'(busy[0]), 64'd0);
        check(1, "abort_we", 64'(we[1]), 64'd0);
        go_to(fs + 560);
        check(0, "abort_no_done", 64'(done_cnt[0] - dn0), 64'd0);
        check(1, "abort_no_done", 64'(done_cnt[1] - dn1), 64'd0);
        run_frame(fs);
        check(0, "post_reset_peak_bin", 64'(pbin[0]), 64'd3);
        check(1, "post_reset_first_write", 64'(w0_cyc[1] - fs), 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spectrum_mag_unit.md
Name: spectrum_mag_unit

Overview:
Downstream of the FFT block. On the FFT's end-of-transform pulse, it reads the first half of the complex result RAM (bins 0..N_POINTS/2-1) and computes the power of each bin as re²+im². It scales and saturates each power value, then writes it to the display/magnitude buffer. It also tracks the peak bin for the frame and signals completion with a one-cycle pulse.

Parameters:
N_POINTS, 1024, FFT length; must be a power of 2, at least 4
ADDR_WIDTH, 10, log2(N_POINTS)
DATA_WIDTH, 32, width of the signed real and imaginary parts of each FFT result
OUT_WIDTH, 16, width of the unsigned power output
SHIFT, 32, right shift applied to re²+im² before saturation
RAM_LATENCY, 1, cycles from fft_addr_o to valid fft_real_i/fft_img_i (allowed 1..3)
EXCLUDE_DC, 1, 1 = bin 0 is not a peak candidate

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start_i  in  1  one-cycle pulse from the FFT end_o
busy_o  out  1  frame in progress
done_o  out  1  one-cycle frame-complete pulse
fft_addr_o  out  ADDR_WIDTH  FFT result RAM read address
fft_real_i  in  DATA_WIDTH  signed real part, read data
fft_img_i  in  DATA_WIDTH  signed imaginary part, read data
mag_we_o  out  1  magnitude buffer write strobe
mag_addr_o  out  ADDR_WIDTH-1  magnitude buffer write address
mag_data_o  out  OUT_WIDTH  scaled, saturated power
peak_bin_o  out  ADDR_WIDTH-1  bin index of the last frame's maximum
peak_val_o  out  OUT_WIDTH  value of the last frame's maximum

Behaviour:
- Reset: all outputs and internal registers are 0; state IDLE.
- Reset asserted mid-frame aborts the frame: no further writes, no done_o, peak outputs cleared to 0.
- State machine IDLE -> READ -> DRAIN -> DONE -> IDLE.
  - IDLE: start_i=1 -> READ. start_i is ignored in every other state, and is not queued.
  - READ: fft_addr_o steps 0,1,...,N_POINTS/2-1, one address per cycle, registered. After issuing N_POINTS/2-1 -> DRAIN.
  - DRAIN: wait until the last write has been issued -> DONE.
  - DONE: done_o=1 for exactly one cycle; peak_bin_o/peak_val_o updated the same cycle -> IDLE.
- Timing (start_i sampled at edge 0):
  - fft_addr_o=0 is valid in cycle 1, and busy_o=1 from cycle 1.
  - fft_addr_o=k in cycle 1+k.
  - Fixed pipeline latency L = RAM_LATENCY+3: mag_we_o=1 with mag_addr_o=k in cycle 1+k+L.
  - mag_we_o is high for N_POINTS/2 consecutive cycles.
  - done_o is high in cycle N_POINTS/2+L+1. busy_o falls in the same cycle done_o rises.
- Pipeline stages after data valid:
  - S1: register re and im.
  - S2: signed squares, each 2*DATA_WIDTH bits unsigned.
  - S3: sum to 2*DATA_WIDTH+1 bits, shift right by SHIFT, saturate: if the result is at least 2^OUT_WIDTH, output 2^OUT_WIDTH-1.
  - Write registers follow S3.
  - The most-negative input (-2^(DATA_WIDTH-1)) must square correctly with no overflow.
- Peak tracking uses the post-saturation values:
  - Running max is initialised at the start of each frame to value 0, bin 0.
  - Update only on a strictly greater value, so the earliest bin wins ties.
  - If EXCLUDE_DC=1, bin 0 is skipped.
  - peak_* outputs hold the previous frame's result until DONE.
- When idle: fft_addr_o, mag_addr_o and mag_data_o hold their last values; mag_we_o=0.
- start_i coincident with done_o (state DONE) is ignored.

Test Plan:
- All-zero RAM, default params, start pulse -> 512 writes of 0 in cycles 5..516. done_o pulses at cycle 517. peak_bin_o=0, peak_val_o=0.
- Bin 5 re=2^20, im=0, all other bins 0 -> mag_data_o=256 at mag_addr_o=5, others 0. peak_bin_o=5, peak_val_o=256.
- Bin 7 re=im=-2^31 -> power 2^63 >> 32 = 2^31, saturates to 65535 at address 7, no wrap.
- Bins 3 and 9 both power 1000, bin 0 power 5000 with EXCLUDE_DC=1 -> peak_bin_o=3, peak_val_o=1000. Repeat with EXCLUDE_DC=0 -> peak_bin_o=0, peak_val_o=5000.
- Extra start_i pulses at cycles 50 and 517 (during DONE) -> ignored: exactly 512 writes and one done_o. Then a start_i in IDLE at cycle 520 -> new frame begins with fft_addr_o=0 at cycle 521.
- Reset asserted at cycle 200 -> next cycle all outputs 0, state IDLE, no done_o. A fresh start_i completes a normal frame. Rerun with RAM_LATENCY=3 -> first write at cycle 7.
